// File: rtl/coin_acceptor.sv
// Coin acceptor front end: turns bouncy coin-sensor lines into spaced one-cycle coin codes.
// Latency: code appears DEBOUNCE_CYCLES+4 cycles after the first edge sampling a clean raw high.
// Backpressure: none downstream; a full queue with no pop this cycle, a jam or accept_en_i=0 rejects the coin.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   coin5_raw_i       asynchronous 5-unit sensor (high while a coin passes, bouncy)
//   coin10_raw_i      asynchronous 10-unit sensor (high while a coin passes, bouncy)
//   accept_en_i       1 = queue detected coins, 0 = return them
//   coin_code_o       01 = 5, 10 = 10, 00 = none; non-zero for exactly one cycle per coin
//   coin_reject_o     one-cycle pulse when a detected coin is returned
//   fifo_count_o      coins queued and not yet emitted
//   busy_o            queue non-empty or output sequencer not idle
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        coin5_raw_i,
    input  logic                        coin10_raw_i,
    input  logic                        accept_en_i,
    output logic [1:0]                  coin_code_o,
    output logic                        coin_reject_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Bit 0 is the 5-unit line, bit 1 the 10-unit line. This ordering makes an
    // event vector with a single bit set equal to the coin code to emit.
    logic [1:0]    raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    deb_q;
    logic [1:0]    deb_prev_q;
    logic [1:0]    ev_q;
    logic [DW-1:0] db_cnt_q [2];

    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [1:0]    coin_code_q, coin_code_d;
    logic          reject_q, reject_d;

    logic          pop;
    logic          push;
    logic          full;
    logic          jam;
    logic [1:0]    head;

    assign raw = {coin10_raw_i, coin5_raw_i};

    // Synchroniser, debounce and rising-edge detect for both sensor lines.
    // The debounced level only moves after DEBOUNCE_CYCLES consecutive synced
    // cycles disagreeing with it; any agreeing cycle restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            ev_q       <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            ev_q       <= deb_q & ~deb_prev_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_q[i]    <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Event resolution. A pop in the same cycle frees a slot, so a full queue
    // still accepts a coin when the sequencer is draining it.
    assign head = mem_q[rd_ptr_q];
    assign full = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign jam  = &ev_q;

    always_comb begin
        push     = (|ev_q) && !jam && accept_en_i && (!full || pop);
        reject_d = (|ev_q) && !push;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ev_q;
        end
    end

    // Output sequencer: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gap_cnt_q   <= '0;
            coin_code_q <= 2'b00;
            reject_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            coin_code_q <= coin_code_d;
            reject_q    <= reject_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Output sequencer: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output sequencer: outputs. The vending FSM has no handshake, so each code
    // is followed by at least one 00 cycle (EMIT) plus GAP_CYCLES more.
    always_comb begin
        pop         = 1'b0;
        coin_code_d = 2'b00;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop         = 1'b1;
                    coin_code_d = head;
                end
            end
            S_EMIT: begin
                gap_cnt_d = GW'(1);
            end
            S_GAP: begin
                if (gap_cnt_q != GW'(GAP_CYCLES)) begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    assign coin_code_o   = coin_code_q;
    assign coin_reject_o = reject_q;
    assign fifo_count_o  = count_q;
    assign busy_o        = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: a per-cycle vector table for single coins, glitches and
// jams, then hand-written sequences for queueing, overflow, disable and mid-run reset.
// u_dut uses GAP_CYCLES=1; u_slow (GAP_CYCLES=37) shares the stimulus so its queue can fill.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin5 = 1'b0;
    logic       coin10 = 1'b0;
    logic       en = 1'b1;
    logic [1:0] code_m, code_s;
    logic       rej_m, rej_s;
    logic [2:0] cnt_m, cnt_s;
    logic       busy_m, busy_s;

    always #5 clk = ~clk;

    coin_acceptor #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4), .GAP_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .coin5_raw_i(coin5), .coin10_raw_i(coin10),
        .accept_en_i(en), .coin_code_o(code_m), .coin_reject_o(rej_m),
        .fifo_count_o(cnt_m), .busy_o(busy_m)
    );

    coin_acceptor #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4), .GAP_CYCLES(37)) u_slow (
        .clk(clk), .rst(rst), .coin5_raw_i(coin5), .coin10_raw_i(coin10),
        .accept_en_i(en), .coin_code_o(code_s), .coin_reject_o(rej_s),
        .fifo_count_o(cnt_s), .busy_o(busy_s)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Running event tallies, sampled mid-cycle.
    int codes_m = 0, rejs_m = 0, codes_s = 0, rejs_s = 0;
    int bad11 = 0, close_m = 0, last_m = -100;

    always @(negedge clk) begin
        if (code_m != 2'b00) begin
            codes_m++;
            if (cyc - last_m < 3) close_m++;
            last_m = cyc;
        end
        if (rej_m) rejs_m++;
        if (code_s != 2'b00) codes_s++;
        if (rej_s) rejs_s++;
        if (code_m == 2'b11 || code_s == 2'b11) bad11++;
    end

    typedef struct {
        logic       c5;
        logic       c10;
        logic       en;
        logic [1:0] code;
        logic       rej;
        logic [2:0] cnt;
        logic       bsy;
    } vec_t;

    localparam int NV = 45;
    vec_t tbl [NV];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int cm0, rm0, cs0, rs0;

    initial begin
        // Row j: inputs applied before edge j, outputs checked just after edge j.
        for (int i = 0; i < NV; i++) begin
            tbl[i] = '{c5: 1'b0, c10: 1'b0, en: 1'b1, code: 2'b00, rej: 1'b0, cnt: 3'd0, bsy: 1'b0};
        end
        // Clean 5-unit coin, 10 cycles high: push at edge 7, code at edge 8, GAP until edge 10.
        for (int i = 0; i < 10; i++) tbl[i].c5 = 1'b1;
        tbl[7].cnt = 3'd1; tbl[7].bsy = 1'b1;
        tbl[8].code = 2'b01; tbl[8].bsy = 1'b1;
        tbl[9].bsy = 1'b1;
        // 3-cycle glitch on the 10-unit line: nothing happens.
        for (int i = 17; i < 20; i++) tbl[i].c10 = 1'b1;
        // Both lines rise together: jam, reject at edge 28+7.
        for (int i = 28; i < 38; i++) begin
            tbl[i].c5  = 1'b1;
            tbl[i].c10 = 1'b1;
        end
        tbl[35].rej = 1'b1;

        // Reset state.
        rst = 1'b1;
        repeat (3) step();
        check("reset code", code_m, 0);
        check("reset reject", rej_m, 0);
        check("reset count", cnt_m, 0);
        check("reset busy", busy_m, 0);
        check("reset slow code", code_s, 0);
        check("reset slow count", cnt_s, 0);
        rst = 1'b0;
        repeat (3) step();

        for (int i = 0; i < NV; i++) begin
            coin5  = tbl[i].c5;
            coin10 = tbl[i].c10;
            en     = tbl[i].en;
            step();
            check($sformatf("vec%0d code", i), code_m, tbl[i].code);
            check($sformatf("vec%0d reject", i), rej_m, tbl[i].rej);
            check($sformatf("vec%0d count", i), cnt_m, tbl[i].cnt);
            check($sformatf("vec%0d busy", i), busy_m, tbl[i].bsy);
        end
        coin5 = 1'b0; coin10 = 1'b0;

        // Seven 5-unit coins every 8 cycles (4 high, 4 low). Pushes at 7+8k.
        // u_slow pops at 8 and 47: full at 46, push+pop at 47, drop at 55.
        rst = 1'b1; step(); rst = 1'b0; step(); step();
        cm0 = codes_m; rm0 = rejs_m; cs0 = codes_s; rs0 = rejs_s;
        for (int e = 0; e < 56; e++) begin
            coin5 = ((e % 8) < 4);
            step();
            if (e == 7)  check("q main count after first push", cnt_m, 1);
            if (e == 8)  check("q main first code", code_m, 1);
            if (e == 46) check("q slow count full", cnt_s, 4);
            if (e == 47) begin
                check("q slow code on push+pop", code_s, 1);
                check("q slow count push+pop full", cnt_s, 4);
                check("q slow no reject push+pop", rej_s, 0);
            end
            if (e == 55) begin
                check("q slow overflow reject", rej_s, 1);
                check("q slow count after drop", cnt_s, 4);
            end
        end
        coin5 = 1'b0;
        repeat (160) step();
        check("q main codes emitted", codes_m - cm0, 7);
        check("q main rejects", rejs_m - rm0, 0);
        check("q slow codes emitted", codes_s - cs0, 6);
        check("q slow rejects", rejs_s - rs0, 1);
        check("q slow drained count", cnt_s, 0);

        // Disabled acceptor returns a 10-unit coin, then accepts the next one.
        cm0 = codes_m; rm0 = rejs_m;
        en = 1'b0;
        for (int e = 0; e < 16; e++) begin
            coin10 = (e < 4);
            step();
            if (e == 7) begin
                check("dis reject pulse", rej_m, 1);
                check("dis count", cnt_m, 0);
            end
        end
        check("dis rejects", rejs_m - rm0, 1);
        check("dis codes", codes_m - cm0, 0);
        en = 1'b1;
        for (int e = 0; e < 16; e++) begin
            coin10 = (e < 4);
            step();
            if (e == 7) check("ena count", cnt_m, 1);
            if (e == 8) check("ena code 10", code_m, 2);
        end
        check("ena codes", codes_m - cm0, 1);
        check("ena rejects", rejs_m - rm0, 1);

        // Reset with three coins queued in u_slow.
        rst = 1'b1; step(); rst = 1'b0; step(); step();
        for (int e = 0; e < 32; e++) begin
            coin5 = ((e % 8) < 4);
            step();
        end
        coin5 = 1'b0;
        check("rst slow queued", cnt_s, 3);
        check("rst slow busy before", busy_s, 1);
        rst = 1'b1;
        step();
        check("rst slow code", code_s, 0);
        check("rst slow count", cnt_s, 0);
        check("rst slow busy", busy_s, 0);
        check("rst main code", code_m, 0);
        check("rst main count", cnt_m, 0);
        check("rst main busy", busy_m, 0);
        rst = 1'b0;
        cm0 = codes_m; rm0 = rejs_m; cs0 = codes_s; rs0 = rejs_s;
        repeat (100) step();
        check("rst no late slow codes", codes_s - cs0, 0);
        check("rst no late main codes", codes_m - cm0, 0);
        check("rst no late rejects", (rejs_m - rm0) + (rejs_s - rs0), 0);

        check("never code 11", bad11, 0);
        check("main codes spaced >= 3", close_m, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
